shadow_chain_rx: RTL

Receiving end of the shadow-capture dump chain. Requests a dump from one shadow capture instance (such as the store-buffer state capture in the LSU), deserializes the returned `ch_out` bitstream into fixed-width words, and buffers them in a small FIFO. A host debug port drains the FIFO with a valid/ready handshake. The block sits in the shadow/debug clock domain, alongside the capture instances.

---
 rtl/shadow_chain_rx_if.sv | 24 ++
 rtl/shadow_chain_rx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/shadow_chain_rx_if.sv
// Chain-side and host-side signals of shadow_chain_rx. The master modport is the receiver
// itself; the slave modport is the capture instance plus the host debug port.
interface shadow_chain_rx_if #(
  parameter int unsigned WORD_W = 32
) ();
  logic              dump_en;
  logic              ch_in;
  logic              ch_in_vld;
  logic              ch_in_done;
  logic [WORD_W-1:0] rd_data;
  logic              rd_last;
  logic              rd_vld;
  logic              rd_rdy;

  modport master (
    output dump_en, rd_data, rd_last, rd_vld,
    input  ch_in, ch_in_vld, ch_in_done, rd_rdy
  );

  modport slave (
    input  dump_en, rd_data, rd_last, rd_vld,
    output ch_in, ch_in_vld, ch_in_done, rd_rdy
  );
endinterface

// File: rtl/shadow_chain_rx.sv
// Receiving end of the shadow-capture dump chain: requests a dump, packs the serial stream
// LSB-first into words and queues them for the host. Define SHADOW_RX_LEN_CHECK_EN for len_err.
module shadow_chain_rx #(
  parameter int unsigned DFF_BITS   = 40,
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              sh_clk,
  input  logic              sh_rst_l,
  input  logic              dump_req,
  shadow_chain_rx_if.master bus,
  output logic              busy,
  output logic              ovf,
  output logic              len_err
);

  localparam int unsigned CNT_W  = $clog2(DFF_BITS * 2 + 1);
  localparam int unsigned POS_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {StIdle, StDump, StFlush} state_e;

  state_e            state_q;
  logic              dump_en_q;
  logic              busy_q;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [POS_W-1:0]  pos_q, pos_nxt;
  logic [WORD_W-1:0] sreg_q, word_nxt;
  logic              stg_vld_q;
  logic              stg_last_q;
  logic [WORD_W-1:0] stg_data_q;
  logic              start, shift, complete, done_now, mark;

  logic [WORD_W-1:0]     mem_data_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last_q;
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q, tail_ptr;
  logic [FILL_W-1:0]     fill_q;
  logic                  full, pop, push_ok, drop, tail_mark;
  logic                  last_push_ok_q;
  logic                  ovf_q;

  always_comb begin
    start    = (state_q == StIdle) & dump_req;
    shift    = (state_q == StDump) & bus.ch_in_vld;
    done_now = (state_q == StDump) & bus.ch_in_done;
    complete = shift & (pos_q == POS_W'(WORD_W - 1));
    word_nxt = sreg_q;
    pos_nxt  = pos_q;
    cnt_nxt  = cnt_q;
    if (shift) begin
      word_nxt[pos_q] = bus.ch_in;
      pos_nxt         = complete ? '0 : pos_q + POS_W'(1);
      if (cnt_q != CNT_MAX) cnt_nxt = cnt_q + CNT_W'(1);
    end
    // Done with nothing left over: the previous full word becomes the last one.
    mark = done_now & ~complete & (pos_nxt == '0) & (cnt_nxt != '0);
  end

  // Control FSM; words leave through a one-deep staging register into the FIFO.
  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      state_q    <= StIdle;
      dump_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      cnt_q      <= '0;
      pos_q      <= '0;
      sreg_q     <= '0;
      stg_vld_q  <= 1'b0;
      stg_last_q <= 1'b0;
      stg_data_q <= '0;
    end else begin
      stg_vld_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (dump_req) begin
            state_q   <= StDump;
            dump_en_q <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            pos_q     <= '0;
            sreg_q    <= '0;
          end
        end
        StDump: begin
          cnt_q  <= cnt_nxt;
          pos_q  <= pos_nxt;
          sreg_q <= complete ? '0 : word_nxt;
          if (complete | (done_now & ~mark)) begin
            stg_vld_q  <= 1'b1;
            stg_data_q <= word_nxt;
            stg_last_q <= done_now;
          end
          if (done_now) begin
            state_q   <= StFlush;
            dump_en_q <= 1'b0;
          end
        end
        StFlush: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    full      = (fill_q == FILL_W'(FIFO_DEPTH));
    pop       = (fill_q != '0) & bus.rd_rdy;
    push_ok   = stg_vld_q & (~full | pop);
    drop      = stg_vld_q & full & ~pop;
    tail_ptr  = wr_ptr_q - PTR_W'(1);
    // Only flag the tail if it is still this dump's word sitting in the FIFO.
    tail_mark = mark & ~stg_vld_q & last_push_ok_q & (fill_q != '0);
  end

  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_data_q[i] <= '0;
      mem_last_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fill_q         <= '0;
      last_push_ok_q <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_data_q[wr_ptr_q] <= stg_data_q;
        mem_last_q[wr_ptr_q] <= stg_last_q | mark;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (tail_mark) mem_last_q[tail_ptr] <= 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fill_q <= fill_q + FILL_W'(1);
        2'b01:   fill_q <= fill_q - FILL_W'(1);
        default: fill_q <= fill_q;
      endcase
      if (start) begin
        ovf_q          <= 1'b0;
        last_push_ok_q <= 1'b0;
      end else if (stg_vld_q) begin
        last_push_ok_q <= push_ok;
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

`ifdef SHADOW_RX_LEN_CHECK_EN
  logic len_err_q;

  always_ff @(posedge sh_clk or negedge sh_rst_l) begin
    if (!sh_rst_l) begin
      len_err_q <= 1'b0;
    end else if (start) begin
      len_err_q <= 1'b0;
    end else if ((state_q == StFlush) && (cnt_q != CNT_W'(DFF_BITS))) begin
      len_err_q <= 1'b1;
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

  assign bus.dump_en = dump_en_q;
  assign bus.rd_data = mem_data_q[rd_ptr_q];
  assign bus.rd_last = mem_last_q[rd_ptr_q];
  assign bus.rd_vld  = (fill_q != '0);
  assign busy        = busy_q;
  assign ovf         = ovf_q;

endmodule
